// File: rtl/dlk_pkg.sv
// Shared constants, FSM state type and parity helper for the downlink serializer.
package dlk_pkg;
   localparam int WORD_W  = 16;
   localparam int SYNC_W  = 8;
   localparam int FRAME_W = SYNC_W + 2 * (WORD_W + 1);
   localparam int CNT_W   = 6;

   localparam logic [SYNC_W-1:0] SYNC_CODE = 8'hE4;

   // Bit counts at which each frame section ends
   localparam logic [CNT_W-1:0] CNT_SYNC_END  = CNT_W'(SYNC_W);
   localparam logic [CNT_W-1:0] CNT_W34_END   = CNT_W'(SYNC_W + WORD_W + 1);
   localparam logic [CNT_W-1:0] CNT_FRAME_END = CNT_W'(FRAME_W);

   typedef enum logic [1:0] {DLK_IDLE, DLK_SYNC, DLK_W34, DLK_W35} dlk_state_e;

   // Parity bit that makes the word plus parity carry an odd count of ones
   function automatic logic odd_par(input logic [WORD_W-1:0] w);
      return ~^w;
   endfunction
endpackage

// File: rtl/dlk_shiftreg.sv
// 42-bit frame shift register, MSB first, with a count of bits shifted out.
module dlk_shiftreg
   import dlk_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               load_i,
   input  logic               shift_i,
   input  logic [FRAME_W-1:0] par_i,
   output logic               ser_o,
   output logic [CNT_W-1:0]   cnt_o
);

   logic [FRAME_W-1:0] sr_q;
   logic [CNT_W-1:0]   cnt_q;

   // Zeros shift in, so the register is empty once the last bit has gone
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (load_i) begin
         sr_q  <= par_i;
         cnt_q <= '0;
      end else if (shift_i) begin
         sr_q  <= {sr_q[FRAME_W-2:0], 1'b0};
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign ser_o = sr_q[FRAME_W-1];
   assign cnt_o = cnt_q;

endmodule

// File: rtl/downlink_serializer.sv
// Channel 34/35 registers and the framing FSM that serializes them with sync and odd parity.
module downlink_serializer
   import dlk_pkg::*;
(
   input  logic              SIM_CLK,
   input  logic              SIM_RST_n,
   input  logic [WORD_W-1:0] WL,
   input  logic              WCH34_n,
   input  logic              WCH35_n,
   input  logic              CCH34,
   input  logic              CCH35,
   input  logic              DLK_START,
   input  logic              DLK_BITSTB,
   output logic [WORD_W-1:0] CH34_Q,
   output logic [WORD_W-1:0] CH35_Q,
   output logic              DLKDATA,
   output logic              DLKGATE,
   output logic              DOWNRUPT,
   output logic              DLK_OVRN
);

   logic [WORD_W-1:0] ch34_q, ch34_d, ch35_q, ch35_d;
   dlk_state_e        state_q;
   logic              gate_q, rupt_q, ovrn_q;
   logic              busy, load, shift;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [FRAME_W-1:0] frame;

   // A write beats a clear in the same cycle
   always_comb begin
      ch34_d = ch34_q;
      if (!WCH34_n)   ch34_d = WL;
      else if (CCH34) ch34_d = '0;
      ch35_d = ch35_q;
      if (!WCH35_n)   ch35_d = WL;
      else if (CCH35) ch35_d = '0;
   end

   always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
      if (!SIM_RST_n) begin
         ch34_q <= '0;
         ch35_q <= '0;
      end else begin
         ch34_q <= ch34_d;
         ch35_q <= ch35_d;
      end
   end

   assign busy    = (state_q != DLK_IDLE);
   assign load    = !busy && DLK_START;
   assign shift   = busy && DLK_BITSTB;
   assign cnt_nxt = cnt + CNT_W'(1);
   assign frame   = {SYNC_CODE, ch34_q, odd_par(ch34_q), ch35_q, odd_par(ch35_q)};

   dlk_shiftreg u_sr (
      .clk_i   (SIM_CLK),
      .rst_n_i (SIM_RST_n),
      .load_i  (load),
      .shift_i (shift),
      .par_i   (frame),
      .ser_o   (DLKDATA),
      .cnt_o   (cnt)
   );

   always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
      if (!SIM_RST_n) begin
         state_q <= DLK_IDLE;
         gate_q  <= 1'b0;
         rupt_q  <= 1'b0;
         ovrn_q  <= 1'b0;
      end else begin
         rupt_q <= 1'b0;
         case (state_q)
            DLK_IDLE: if (DLK_START) begin
               state_q <= DLK_SYNC;
               gate_q  <= 1'b1;
            end
            DLK_SYNC: if (DLK_BITSTB && cnt_nxt == CNT_SYNC_END) state_q <= DLK_W34;
            DLK_W34:  if (DLK_BITSTB && cnt_nxt == CNT_W34_END)  state_q <= DLK_W35;
            DLK_W35:  if (DLK_BITSTB && cnt_nxt == CNT_FRAME_END) begin
               state_q <= DLK_IDLE;
               gate_q  <= 1'b0;
               rupt_q  <= 1'b1;
            end
            default:  state_q <= DLK_IDLE;
         endcase
         // A start that cannot be taken is recorded; it outranks the clear
         if (busy && DLK_START) ovrn_q <= 1'b1;
         else if (CCH34)        ovrn_q <= 1'b0;
      end
   end

   assign CH34_Q   = ch34_q;
   assign CH35_Q   = ch35_q;
   assign DLKGATE  = gate_q;
   assign DOWNRUPT = rupt_q;
   assign DLK_OVRN = ovrn_q;

endmodule

// File: tb/tb_downlink_serializer.sv
// Directed and random stimulus for downlink_serializer, checked against a bit-index frame model.
module tb_downlink_serializer;
   logic        SIM_CLK = 1'b0;
   logic        SIM_RST_n = 1'b0;
   logic [15:0] WL = '0;
   logic        WCH34_n = 1'b1, WCH35_n = 1'b1, CCH34 = 1'b0, CCH35 = 1'b0;
   logic        DLK_START = 1'b0, DLK_BITSTB = 1'b0;
   logic [15:0] CH34_Q, CH35_Q;
   logic        DLKDATA, DLKGATE, DOWNRUPT, DLK_OVRN;

   downlink_serializer dut (
      .SIM_CLK(SIM_CLK), .SIM_RST_n(SIM_RST_n), .WL(WL),
      .WCH34_n(WCH34_n), .WCH35_n(WCH35_n), .CCH34(CCH34), .CCH35(CCH35),
      .DLK_START(DLK_START), .DLK_BITSTB(DLK_BITSTB),
      .CH34_Q(CH34_Q), .CH35_Q(CH35_Q), .DLKDATA(DLKDATA), .DLKGATE(DLKGATE),
      .DOWNRUPT(DOWNRUPT), .DLK_OVRN(DLK_OVRN)
   );

   always #5 SIM_CLK = ~SIM_CLK;

   int n_chk = 0, n_fail = 0, rupt_cnt = 0, gate_cnt = 0, cap_idx = 0;
   logic [41:0] cap, exp_frame;

   // Reference model: a frame is a 42-bit vector and an index of strobes seen
   logic [15:0] m_ch34, m_ch35;
   logic [41:0] m_frame;
   logic        m_busy, m_rupt, m_ovrn;
   int          m_idx;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [41:0] mk_frame(input logic [15:0] a, input logic [15:0] b);
      logic pa, pb;
      pa = ($countones(a) % 2) == 0;
      pb = ($countones(b) % 2) == 0;
      return {8'hE4, a, pa, b, pb};
   endfunction

   task automatic model_step();
      if (!SIM_RST_n) begin
         m_ch34 = '0; m_ch35 = '0; m_frame = '0;
         m_busy = 1'b0; m_rupt = 1'b0; m_ovrn = 1'b0; m_idx = 0;
      end else begin
         m_rupt = 1'b0;
         if (m_busy) begin
            if (DLK_START) m_ovrn = 1'b1;
            else if (CCH34) m_ovrn = 1'b0;
            if (DLK_BITSTB) begin
               m_idx++;
               if (m_idx == 42) begin
                  m_busy = 1'b0;
                  m_rupt = 1'b1;
               end
            end
         end else begin
            if (CCH34) m_ovrn = 1'b0;
            if (DLK_START) begin
               m_frame = mk_frame(m_ch34, m_ch35);
               m_busy  = 1'b1;
               m_idx   = 0;
            end
         end
         if (!WCH34_n) m_ch34 = WL; else if (CCH34) m_ch34 = '0;
         if (!WCH35_n) m_ch35 = WL; else if (CCH35) m_ch35 = '0;
      end
   endtask

   task automatic check_all();
      chk("ch34", CH34_Q, m_ch34);
      chk("ch35", CH35_Q, m_ch35);
      chk("data", DLKDATA, m_busy ? m_frame[41-m_idx] : 1'b0);
      chk("gate", DLKGATE, m_busy);
      chk("rupt", DOWNRUPT, m_rupt);
      chk("ovrn", DLK_OVRN, m_ovrn);
   endtask

   task automatic tick();
      @(posedge SIM_CLK);
      model_step();
      #1;
      check_all();
      if (DOWNRUPT) rupt_cnt++;
      WCH34_n = 1'b1; WCH35_n = 1'b1; CCH34 = 1'b0; CCH35 = 1'b0;
      DLK_START = 1'b0; DLK_BITSTB = 1'b0;
   endtask

   task automatic start_frame();
      DLK_START = 1'b1;
      tick();
      cap = '0; cap_idx = 0; gate_cnt = 0;
   endtask

   // One bit per four clocks; each bit is sampled just before its strobe
   task automatic run_bits(input int n);
      repeat (n) begin
         if (cap_idx < 42) cap[41-cap_idx] = DLKDATA;
         cap_idx++;
         if (DLKGATE) gate_cnt++;
         repeat (3) tick();
         DLK_BITSTB = 1'b1;
         tick();
      end
   endtask

   task automatic wr(input int ch, input logic [15:0] v);
      WL = v;
      if (ch == 34) WCH34_n = 1'b0; else WCH35_n = 1'b0;
      tick();
   endtask

   int r0;

   initial begin
      // Reset held with a write and a start pending
      WL = 16'hFFFF; WCH34_n = 1'b0; DLK_START = 1'b1;
      repeat (3) begin
         @(posedge SIM_CLK); model_step(); #1;
         chk("rst_ch34", CH34_Q, 16'h0);
         chk("rst_gate", DLKGATE, 1'b0);
         chk("rst_data", DLKDATA, 1'b0);
         chk("rst_rupt", DOWNRUPT, 1'b0);
         chk("rst_ovrn", DLK_OVRN, 1'b0);
      end
      SIM_RST_n = 1'b1; DLK_START = 1'b0;
      tick();
      chk("t1_ch34", CH34_Q, 16'hFFFF);

      // Basic frame
      wr(34, 16'h0001);
      wr(35, 16'h0000);
      r0 = rupt_cnt;
      start_frame();
      run_bits(42);
      exp_frame = {8'hE4, 16'h0001, 1'b0, 16'h0000, 1'b1};
      chk("t2_frame", cap, exp_frame);
      chk("t2_gate_ivl", gate_cnt, 42);
      chk("t2_rupts", rupt_cnt - r0, 1);
      repeat (2) tick();

      // Write and clear in the same cycle
      WL = 16'h1234; WCH35_n = 1'b0; CCH35 = 1'b1;
      tick();
      chk("t3_wr_wins", CH35_Q, 16'h1234);
      CCH35 = 1'b1;
      tick();
      chk("t3_clr", CH35_Q, 16'h0);

      // Write mid-frame only affects the next frame
      wr(34, 16'hAAAA);
      start_frame();
      run_bits(12);
      wr(34, 16'h5555);
      run_bits(30);
      exp_frame = {8'hE4, 16'hAAAA, 1'b1, 16'h0000, 1'b1};
      chk("t4_frame1", cap, exp_frame);
      start_frame();
      run_bits(42);
      exp_frame = {8'hE4, 16'h5555, 1'b1, 16'h0000, 1'b1};
      chk("t4_frame2", cap, exp_frame);

      // Start while busy
      r0 = rupt_cnt;
      start_frame();
      run_bits(20);
      DLK_START = 1'b1;
      tick();
      run_bits(22);
      chk("t5_frame", cap, exp_frame);
      chk("t5_ovrn", DLK_OVRN, 1'b1);
      chk("t5_rupts", rupt_cnt - r0, 1);
      CCH34 = 1'b1;
      tick();
      chk("t5_ovrn_clr", DLK_OVRN, 1'b0);

      // Strobe alone in idle, then start and strobe together
      DLK_BITSTB = 1'b1;
      tick();
      chk("b_idle_gate", DLKGATE, 1'b0);
      wr(34, 16'h8001);
      DLK_START = 1'b1; DLK_BITSTB = 1'b1;
      tick();
      cap = '0; cap_idx = 0;
      chk("b_ss_data", DLKDATA, 1'b1);
      chk("b_ss_gate", DLKGATE, 1'b1);
      run_bits(41);
      cap[0] = DLKDATA;
      chk("b_ss_frame", cap, mk_frame(16'h8001, 16'h0000));
      // Start coinciding with the final strobe
      repeat (3) tick();
      DLK_START = 1'b1; DLK_BITSTB = 1'b1;
      tick();
      chk("b_end_rupt", DOWNRUPT, 1'b1);
      chk("b_end_gate", DLKGATE, 1'b0);
      chk("b_end_ovrn", DLK_OVRN, 1'b1);
      tick();
      chk("b_end_nostart", DLKGATE, 1'b0);

      // Reset mid-frame
      start_frame();
      run_bits(30);
      r0 = rupt_cnt;
      #2 SIM_RST_n = 1'b0;
      model_step();
      #1;
      chk("t6_gate", DLKGATE, 1'b0);
      chk("t6_data", DLKDATA, 1'b0);
      chk("t6_rupt", DOWNRUPT, 1'b0);
      repeat (2) begin
         @(posedge SIM_CLK); model_step(); #1;
         chk("t6_hold_rupt", DOWNRUPT, 1'b0);
      end
      SIM_RST_n = 1'b1;
      tick();
      chk("t6_no_rupt", rupt_cnt - r0, 0);
      start_frame();
      chk("t6_sync_msb", DLKDATA, 1'b1);
      chk("t6_gate_on", DLKGATE, 1'b1);

      // Random traffic against the model
      repeat (1500) begin
         WL         = 16'($urandom);
         WCH34_n    = ($urandom_range(0, 9) != 0);
         WCH35_n    = ($urandom_range(0, 9) != 0);
         CCH34      = ($urandom_range(0, 19) == 0);
         CCH35      = ($urandom_range(0, 19) == 0);
         DLK_START  = ($urandom_range(0, 49) == 0);
         DLK_BITSTB = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
